fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the ASCA integer pipeline. Sits beside decode.

---
 rtl/fwd_hazard_unit_pkg.sv | 69 ++++++
 rtl/fwd_decode.sv | 35 +++
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared opcode encodings, operand-class bits and the opcode classifier for
// the forwarding/hazard unit and its decoder.
package fwd_hazard_unit_pkg;

   localparam int REG_N_DEF    = 4;
   localparam int OPCODE_W_DEF = 5;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_MUL  = 5'd1,
      OP_AND  = 5'd2,
      OP_ORR  = 5'd3,
      OP_XOR  = 5'd4,
      OP_STR  = 5'd5,
      OP_CMP  = 5'd6,
      OP_MOV  = 5'd7,
      OP_LDR  = 5'd8,
      OP_NOT  = 5'd9,
      OP_ADDI = 5'd10,
      OP_LSR  = 5'd11,
      OP_LSL  = 5'd12,
      OP_ASR  = 5'd13,
      OP_BLX  = 5'd14,
      OP_PUSH = 5'd15,
      OP_POP  = 5'd16,
      OP_LDRL = 5'd17,
      OP_LDRH = 5'd18
   } opcode_e;

   // Class-bit positions inside an operand-class word.
   localparam int CB_USE_A      = 0;
   localparam int CB_USE_B      = 1;
   localparam int CB_SRC_A_IS_B = 2;
   localparam int CB_HAS_DST    = 3;
   localparam int CB_DST_LINK   = 4;
   localparam int CB_IS_LOAD    = 5;
   localparam int CLS_W         = 6;

   localparam logic [CLS_W-1:0] CLS_NONE   = 6'b000000;
   localparam logic [CLS_W-1:0] CLS_ALU    = 6'b001011;
   localparam logic [CLS_W-1:0] CLS_STORE  = 6'b000011;
   localparam logic [CLS_W-1:0] CLS_MOVE   = 6'b001010;
   localparam logic [CLS_W-1:0] CLS_LOAD_B = 6'b101010;
   localparam logic [CLS_W-1:0] CLS_UNARY  = 6'b001001;
   localparam logic [CLS_W-1:0] CLS_LINK   = 6'b011001;
   localparam logic [CLS_W-1:0] CLS_PUSH   = 6'b000001;
   localparam logic [CLS_W-1:0] CLS_POP    = 6'b101000;
   localparam logic [CLS_W-1:0] CLS_CONST  = 6'b001000;

   function automatic logic [CLS_W-1:0] op_class(input logic [31:0] op);
      logic [CLS_W-1:0] cls;
      case (op)
         32'(OP_ADD), 32'(OP_MUL), 32'(OP_AND),
         32'(OP_ORR), 32'(OP_XOR):                 cls = CLS_ALU;
         32'(OP_STR), 32'(OP_CMP):                 cls = CLS_STORE;
         32'(OP_MOV):                              cls = CLS_MOVE;
         32'(OP_LDR):                              cls = CLS_LOAD_B;
         32'(OP_NOT), 32'(OP_ADDI), 32'(OP_LSR),
         32'(OP_LSL), 32'(OP_ASR):                 cls = CLS_UNARY;
         32'(OP_BLX):                              cls = CLS_LINK;
         32'(OP_PUSH):                             cls = CLS_PUSH;
         32'(OP_POP):                              cls = CLS_POP;
         32'(OP_LDRL), 32'(OP_LDRH):               cls = CLS_CONST;
         default:                                  cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/fwd_decode.sv
// Combinational opcode decoder: which register fields are read, which one is
// written, and whether the result comes from memory.
module fwd_decode
   import fwd_hazard_unit_pkg::*;
#(
   parameter int                REG_N    = REG_N_DEF,
   parameter int                OPCODE_W = OPCODE_W_DEF,
   parameter logic [REG_N-1:0]  LINK_REG = {REG_N{1'b1}}
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_N-1:0]    nREGA,
   input  logic [REG_N-1:0]    nREGB,
   output logic [REG_N-1:0]    src_a,
   output logic [REG_N-1:0]    src_b,
   output logic                use_a,
   output logic                use_b,
   output logic [REG_N-1:0]    dst,
   output logic                has_dst,
   output logic                is_load
);

   logic [CLS_W-1:0] cls;

   always_comb begin
      cls     = op_class(32'(opcode));
      use_a   = cls[CB_USE_A];
      use_b   = cls[CB_USE_B];
      has_dst = cls[CB_HAS_DST];
      is_load = cls[CB_IS_LOAD];
      src_a   = cls[CB_SRC_A_IS_B] ? nREGB : nREGA;
      src_b   = nREGB;
      dst     = cls[CB_DST_LINK] ? LINK_REG : nREGA;
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation over the last FWD_DEPTH
// issued destinations. Define FWD_HAZARD_STATS_EN to add fwd_cnt/stall_cnt.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int               REG_N     = REG_N_DEF,
   parameter int               OPCODE_W  = OPCODE_W_DEF,
   parameter int               FWD_DEPTH = 2,
   parameter int               LOAD_GAP  = 1,
   parameter logic [REG_N-1:0] LINK_REG  = {REG_N{1'b1}},
   localparam int              SEL_W     = $clog2(FWD_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_N-1:0]    nREGA,
   input  logic [REG_N-1:0]    nREGB,
   input  logic                flush,
   output logic                stall,
   output logic [SEL_W-1:0]    fwd_sel_a,
   output logic [SEL_W-1:0]    fwd_sel_b,
   output logic                fwd_en
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [15:0]         fwd_cnt,
   output logic [15:0]         stall_cnt
`endif
);

   // Handshake: an instruction issues on a clock edge where in_valid=1 and
   // stall=0; while stall=1 upstream must present the same instruction again.

   logic [REG_N-1:0] src_a, src_b, dst;
   logic             use_a, use_b, has_dst, is_load;

   fwd_decode #(
      .REG_N    (REG_N),
      .OPCODE_W (OPCODE_W),
      .LINK_REG (LINK_REG)
   ) u_decode (
      .opcode  (opcode),
      .nREGA   (nREGA),
      .nREGB   (nREGB),
      .src_a   (src_a),
      .src_b   (src_b),
      .use_a   (use_a),
      .use_b   (use_b),
      .dst     (dst),
      .has_dst (has_dst),
      .is_load (is_load)
   );

   logic [FWD_DEPTH:1] h_valid;
   logic [FWD_DEPTH:1] h_load;
   logic [REG_N-1:0]   h_dst [1:FWD_DEPTH];
   logic [FWD_DEPTH:1] hit_a, hit_b;

   for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_cmp
      assign hit_a[k] = h_valid[k] && (h_dst[k] == src_a);
      assign hit_b[k] = h_valid[k] && (h_dst[k] == src_b);
   end

   logic [SEL_W-1:0] match_a, match_b, sel_a_next, sel_b_next;
   logic             late_a, late_b, hazard;

   // Scan oldest to youngest so the youngest hit is the one that sticks.
   always_comb begin
      match_a = '0;
      match_b = '0;
      late_a  = 1'b0;
      late_b  = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (hit_a[k]) begin
            match_a = SEL_W'(k);
            late_a  = h_load[k] && (k <= LOAD_GAP);
         end
         if (hit_b[k]) begin
            match_b = SEL_W'(k);
            late_b  = h_load[k] && (k <= LOAD_GAP);
         end
      end
      sel_a_next = (in_valid && use_a) ? match_a : '0;
      sel_b_next = (in_valid && use_b) ? match_b : '0;
      hazard     = in_valid && ((use_a && late_a) || (use_b && late_b));
      stall      = hazard && !flush && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         h_valid   <= '0;
         h_load    <= '0;
         fwd_sel_a <= '0;
         fwd_sel_b <= '0;
         fwd_en    <= 1'b0;
      end else begin
         for (int k = FWD_DEPTH; k >= 2; k--) begin
            h_valid[k] <= h_valid[k-1];
            h_load[k]  <= h_load[k-1];
            h_dst[k]   <= h_dst[k-1];
         end
         h_valid[1] <= in_valid && has_dst && !stall;
         h_load[1]  <= is_load;
         h_dst[1]   <= dst;
         fwd_sel_a  <= stall ? '0 : sel_a_next;
         fwd_sel_b  <= stall ? '0 : sel_b_next;
         fwd_en     <= !stall && ((|sel_a_next) || (|sel_b_next));
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (fwd_en && (fwd_cnt != 16'hFFFF))
            fwd_cnt <= fwd_cnt + 16'd1;
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus randomized traffic against a queue-based history model.
module tb_fwd_hazard_unit;
   import fwd_hazard_unit_pkg::*;

   localparam int FWD_DEPTH = 2;
   localparam int LOAD_GAP  = 1;
   localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

   logic clk = 1'b0;
   logic reset, in_valid, flush;
   logic [4:0] opcode;
   logic [3:0] nREGA, nREGB;
   logic stall, fwd_en;
   logic [SEL_W-1:0] fwd_sel_a, fwd_sel_b;
`ifdef FWD_HAZARD_STATS_EN
   logic [15:0] fwd_cnt, stall_cnt;
`endif

   always #5 clk = ~clk;

   fwd_hazard_unit #(
      .REG_N (4), .OPCODE_W (5), .FWD_DEPTH (FWD_DEPTH), .LOAD_GAP (LOAD_GAP),
      .LINK_REG (4'hF)
   ) dut (
      .clk (clk), .reset (reset), .in_valid (in_valid), .opcode (opcode),
      .nREGA (nREGA), .nREGB (nREGB), .flush (flush), .stall (stall),
      .fwd_sel_a (fwd_sel_a), .fwd_sel_b (fwd_sel_b), .fwd_en (fwd_en)
`ifdef FWD_HAZARD_STATS_EN
      , .fwd_cnt (fwd_cnt), .stall_cnt (stall_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Model history: index 0 is the youngest issued instruction.
   typedef struct { bit v; bit [3:0] dst; bit ld; } ent_t;
   ent_t mdl_hist[$];
   bit   e_stall, m_en;
   int   e_sa, e_sb, m_fcnt, m_scnt;
   logic o_stall, o_en;
   logic [SEL_W-1:0] o_sa, o_sb;

   function automatic void mdl_decode(input logic [4:0] op, output bit ua, output bit ub,
                                      output bit hd, output bit lk, output bit ld);
      ua = 0; ub = 0; hd = 0; lk = 0; ld = 0;
      case (op)
         OP_ADD, OP_MUL, OP_AND, OP_ORR, OP_XOR: begin ua = 1; ub = 1; hd = 1; end
         OP_STR, OP_CMP:                         begin ua = 1; ub = 1; end
         OP_MOV:                                 begin ub = 1; hd = 1; end
         OP_LDR:                                 begin ub = 1; hd = 1; ld = 1; end
         OP_NOT, OP_ADDI, OP_LSR, OP_LSL, OP_ASR: begin ua = 1; hd = 1; end
         OP_BLX:                                 begin ua = 1; hd = 1; lk = 1; end
         OP_PUSH:                                ua = 1;
         OP_POP:                                 begin hd = 1; ld = 1; end
         OP_LDRL, OP_LDRH:                       hd = 1;
         default: ;
      endcase
   endfunction

   // Youngest-match distance (1-based) of register r, 0 if none; ld reports its load flag.
   function automatic int mdl_find(input logic [3:0] r, output bit ld);
      ld = 0;
      foreach (mdl_hist[i])
         if (mdl_hist[i].v && mdl_hist[i].dst == r) begin
            ld = mdl_hist[i].ld;
            return i + 1;
         end
      return 0;
   endfunction

   task automatic step(input bit rs, input bit fl, input bit v, input logic [4:0] op,
                       input logic [3:0] a, input logic [3:0] b);
      bit ua, ub, hd, lk, ld, lda, ldb;
      int ma, mb;
      reset = rs; flush = fl; in_valid = v; opcode = op; nREGA = a; nREGB = b;
      mdl_decode(op, ua, ub, hd, lk, ld);
      ma = mdl_find(a, lda);
      mb = mdl_find(b, ldb);
      e_stall = v && !fl && !rs &&
                ((ua && ma != 0 && lda && ma <= LOAD_GAP) || (ub && mb != 0 && ldb && mb <= LOAD_GAP));
      e_sa = (rs || fl || !v || !ua || e_stall) ? 0 : ma;
      e_sb = (rs || fl || !v || !ub || e_stall) ? 0 : mb;
      @(negedge clk);
      o_stall = stall;
      @(posedge clk);
      #1;
      o_sa = fwd_sel_a; o_sb = fwd_sel_b; o_en = fwd_en;
      if (rs) begin
         m_fcnt = 0; m_scnt = 0;
      end else begin
         if (e_stall && m_scnt < 16'hFFFF) m_scnt++;
         if (m_en && m_fcnt < 16'hFFFF) m_fcnt++;
      end
      m_en = (e_sa != 0) || (e_sb != 0);
      if (rs || fl) begin
         foreach (mdl_hist[i]) mdl_hist[i].v = 0;
      end else begin
         ent_t e;
         e.v = v && hd && !e_stall;
         e.dst = lk ? 4'hF : a;
         e.ld = ld;
         mdl_hist.push_front(e);
         void'(mdl_hist.pop_back());
      end
   endtask

   task automatic test_reset();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(1, 0, 1, OP_ADD, 4'd1, 4'd1);
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      total++; if (o_sa !== 2'd0 || o_sb !== 2'd0 || o_en !== 1'b0) begin
         bad++; $display("FAIL reset_outs got=%0d/%0d/%b exp=0/0/0", o_sa, o_sb, o_en);
      end
   endtask

   task automatic test_back_to_back();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_ADD, 4'd1, 4'd2);
      step(0, 0, 1, OP_ADD, 4'd3, 4'd1);
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", o_stall); end
      total++; if (o_sb !== 2'd1 || o_sa !== 2'd0) begin
         bad++; $display("FAIL b2b_sel got=a%0d,b%0d exp=a0,b1", o_sa, o_sb);
      end
      total++; if (o_en !== 1'b1) begin bad++; $display("FAIL b2b_en got=%b exp=1", o_en); end
   endtask

   task automatic test_load_use();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_LDR, 4'd4, 4'd5);
      total++; if (o_en !== 1'b0) begin bad++; $display("FAIL ldr_en got=%b exp=0", o_en); end
      step(0, 0, 1, OP_ADD, 4'd6, 4'd4);
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", o_stall); end
      total++; if (o_en !== 1'b0 || o_sb !== 2'd0) begin
         bad++; $display("FAIL lu_bubble got=en%b,b%0d exp=en0,b0", o_en, o_sb);
      end
      step(0, 0, 1, OP_ADD, 4'd6, 4'd4);
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", o_stall); end
      total++; if (o_sb !== 2'd2 || o_en !== 1'b1) begin
         bad++; $display("FAIL lu_fwd got=b%0d,en%b exp=b2,en1", o_sb, o_en);
      end
      step(0, 0, 0, 5'd0, 4'd0, 4'd0);
`ifdef FWD_HAZARD_STATS_EN
      total++; if (stall_cnt !== 16'd1 || fwd_cnt !== 16'd1) begin
         bad++; $display("FAIL lu_stats got=s%0d,f%0d exp=s1,f1", stall_cnt, fwd_cnt);
      end
`endif
   endtask

   task automatic test_youngest();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_ADD, 4'd1, 4'd2);
      step(0, 0, 1, OP_ADD, 4'd1, 4'd3);
      total++; if (o_sa !== 2'd1) begin bad++; $display("FAIL yng_add got=%0d exp=1", o_sa); end
      step(0, 0, 1, OP_MOV, 4'd2, 4'd1);
      total++; if (o_sb !== 2'd1 || o_sa !== 2'd0) begin
         bad++; $display("FAIL yng_mov got=a%0d,b%0d exp=a0,b1", o_sa, o_sb);
      end
   endtask

   task automatic test_link();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_BLX, 4'd7, 4'd0);
      step(0, 0, 1, OP_PUSH, 4'd15, 4'd0);
      total++; if (o_sa !== 2'd1 || o_en !== 1'b1) begin
         bad++; $display("FAIL link_push got=a%0d,en%b exp=a1,en1", o_sa, o_en);
      end
      step(0, 0, 1, OP_CMP, 4'd3, 4'd8);
      total++; if (o_en !== 1'b0) begin bad++; $display("FAIL link_cmp got=%b exp=0", o_en); end
   endtask

   task automatic test_flush();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_ADD, 4'd1, 4'd2);
      step(0, 1, 1, OP_ADD, 4'd1, 4'd1);
      total++; if (o_sa !== 2'd0 || o_sb !== 2'd0 || o_en !== 1'b0) begin
         bad++; $display("FAIL flush_outs got=%0d/%0d/%b exp=0/0/0", o_sa, o_sb, o_en);
      end
      step(0, 0, 1, OP_MOV, 4'd2, 4'd1);
      total++; if (o_sb !== 2'd0) begin bad++; $display("FAIL flush_mov got=%0d exp=0", o_sb); end
   endtask

   task automatic test_reset_in_stall();
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      step(0, 0, 1, OP_LDR, 4'd4, 4'd5);
      step(1, 0, 1, OP_ADD, 4'd6, 4'd4);
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", o_stall); end
      step(0, 0, 1, OP_ADD, 4'd6, 4'd4);
      total++; if (o_stall !== 1'b0 || o_sb !== 2'd0 || o_en !== 1'b0) begin
         bad++; $display("FAIL rst_empty got=st%b,b%0d,en%b exp=0,0,0", o_stall, o_sb, o_en);
      end
   endtask

   task automatic test_random();
      bit v, fl, rs;
      logic [4:0] op;
      logic [3:0] a, b;
      step(1, 0, 0, 5'd0, 4'd0, 4'd0);
      v = 0; op = 0; a = 0; b = 0;
      for (int n = 0; n < 400; n++) begin
         fl = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 49) == 0);
         if (!e_stall) begin
            v  = ($urandom_range(0, 9) != 0);
            op = 5'($urandom_range(0, 20));
            a  = 4'($urandom_range(0, 5));
            b  = 4'($urandom_range(0, 5));
         end
         step(rs, fl, v, op, a, b);
         total++; if (o_stall !== 1'(e_stall)) begin
            bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, o_stall, e_stall);
         end
         total++; if (o_sa !== SEL_W'(e_sa) || o_sb !== SEL_W'(e_sb)) begin
            bad++; $display("FAIL rnd_sel n=%0d got=a%0d,b%0d exp=a%0d,b%0d", n, o_sa, o_sb, e_sa, e_sb);
         end
         total++; if (o_en !== 1'(m_en)) begin
            bad++; $display("FAIL rnd_en n=%0d got=%b exp=%b", n, o_en, m_en);
         end
      end
`ifdef FWD_HAZARD_STATS_EN
      total++; if (fwd_cnt !== 16'(m_fcnt) || stall_cnt !== 16'(m_scnt)) begin
         bad++; $display("FAIL rnd_stats got=f%0d,s%0d exp=f%0d,s%0d", fwd_cnt, stall_cnt, m_fcnt, m_scnt);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < FWD_DEPTH; i++) mdl_hist.push_back('{v: 0, dst: 0, ld: 0});
      e_stall = 0; m_en = 0; m_fcnt = 0; m_scnt = 0;
      reset = 1; flush = 0; in_valid = 0; opcode = 0; nREGA = 0; nREGB = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_youngest();
      test_link();
      test_flush();
      test_reset_in_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
